// File: rtl/rtc_set_ctrl.sv
// Time-set controller for an HH:MM:SS clock chain: conditions the set buttons and
// manual switch, sequences the field being set and issues one-cycle adjust pulses.
module rtc_set_ctrl #(
    parameter int DEB_LEN    = 8,
    parameter int RPT_DLY    = 500,
    parameter int RPT_RATE   = 150,
    parameter int BLINK_HALF = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1khz,
    input  logic       man_sw,
    input  logic [2:0] push_but,
    output logic       run_en,
    output logic [1:0] mode,
    output logic       inc_hr,
    output logic       dec_hr,
    output logic       inc_min,
    output logic       dec_min,
    output logic       clr_sec,
    output logic [5:0] blank_mask
);

    localparam int RPT_MAX = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
    localparam int HW      = $clog2(RPT_MAX + 1);
    localparam int BW      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [HW-1:0] DLY_C      = HW'(RPT_DLY);
    localparam logic [HW-1:0] RATE_C     = HW'(RPT_RATE);
    localparam logic [HW-1:0] HOLD_SAT   = {HW{1'b1}};
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    logic                    man_meta_q, man_sync_q;
    logic [2:0]              but_meta_q, but_sync_q;
    logic [2:0]              btn_s;
    logic [2:0][DEB_LEN-1:0] deb_sr_q, deb_sr_d;
    logic [2:0]              deb_lvl_q, deb_lvl_d;
    logic [2:0]              press_s;
    logic [1:0][HW-1:0]      hold_q, hold_d;
    logic [1:0]              rpt_on_q, rpt_on_d;
    logic [1:0]              arm_q, arm_d;
    logic [1:0]              rpt_s;
    logic [HW-1:0]           hold_inc_s;
    logic [2:0]              evt_q, evt_d;

    state_t                  state_q, state_d;
    logic                    run_en_q, run_en_d;
    logic                    inc_hr_q, inc_hr_d, dec_hr_q, dec_hr_d;
    logic                    inc_min_q, inc_min_d, dec_min_q, dec_min_d;
    logic                    clr_sec_q, clr_sec_d;
    logic                    up_s, dn_s, adj_s;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic [5:0]              blank_mask_q, blank_mask_d;

    // Two-flop synchronisers for the switch and the active-low buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            man_meta_q <= 1'b0;
            man_sync_q <= 1'b0;
            but_meta_q <= 3'b000;
            but_sync_q <= 3'b000;
        end else begin
            man_meta_q <= man_sw;
            man_sync_q <= man_meta_q;
            but_meta_q <= push_but;
            but_sync_q <= but_meta_q;
        end
    end

    assign btn_s = ~but_sync_q;

    // Debounce shift registers with hysteresis on the all-ones / all-zeros pattern.
    always_comb begin
        deb_sr_d  = deb_sr_q;
        deb_lvl_d = deb_lvl_q;
        for (int b = 0; b < 3; b++) begin
            if (tick_1khz) begin
                deb_sr_d[b] = {deb_sr_q[b][DEB_LEN-2:0], btn_s[b]};
            end else begin
                deb_sr_d[b] = deb_sr_q[b];
            end
            if (&deb_sr_d[b]) begin
                deb_lvl_d[b] = 1'b1;
            end else if (~|deb_sr_d[b]) begin
                deb_lvl_d[b] = 1'b0;
            end else begin
                deb_lvl_d[b] = deb_lvl_q[b];
            end
        end
    end

    assign press_s = deb_lvl_d & ~deb_lvl_q;

    // Auto-repeat for up/down; only a press seen outside RUN arms it, so a button
    // still held across a mode change cannot start repeating.
    always_comb begin
        hold_d     = hold_q;
        rpt_on_d   = rpt_on_q;
        arm_d      = arm_q;
        rpt_s      = 2'b00;
        hold_inc_s = '0;
        for (int r = 0; r < 2; r++) begin
            hold_inc_s = (hold_q[r] == HOLD_SAT) ? hold_q[r] : hold_q[r] + HOLD_ONE;
            if (press_s[r+1] && (state_q != ST_RUN)) begin
                arm_d[r]    = 1'b1;
                hold_d[r]   = '0;
                rpt_on_d[r] = 1'b0;
            end else if (!deb_lvl_q[r+1] || (state_q == ST_RUN)) begin
                arm_d[r]    = 1'b0;
                hold_d[r]   = '0;
                rpt_on_d[r] = 1'b0;
            end else if (arm_q[r] && tick_1khz) begin
                if (!rpt_on_q[r] && (hold_inc_s == DLY_C)) begin
                    rpt_s[r]    = 1'b1;
                    rpt_on_d[r] = 1'b1;
                    hold_d[r]   = '0;
                end else if (rpt_on_q[r] && (hold_inc_s == RATE_C)) begin
                    rpt_s[r]    = 1'b1;
                    hold_d[r]   = '0;
                end else begin
                    hold_d[r]   = hold_inc_s;
                end
            end else begin
                hold_d[r] = hold_q[r];
            end
        end
        evt_d = press_s | {rpt_s, 1'b0};
    end

    // Button conditioning state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_sr_q  <= '0;
            deb_lvl_q <= 3'b000;
            hold_q    <= '0;
            rpt_on_q  <= 2'b00;
            arm_q     <= 2'b00;
            evt_q     <= 3'b000;
        end else begin
            deb_sr_q  <= deb_sr_d;
            deb_lvl_q <= deb_lvl_d;
            hold_q    <= hold_d;
            rpt_on_q  <= rpt_on_d;
            arm_q     <= arm_d;
            evt_q     <= evt_d;
        end
    end

    assign up_s = evt_q[1] & ~evt_q[2];
    assign dn_s = evt_q[2] & ~evt_q[1];

    // Mode sequencing; leaving set mode beats everything, next beats up/down.
    always_comb begin
        state_d   = state_q;
        inc_hr_d  = 1'b0;
        dec_hr_d  = 1'b0;
        inc_min_d = 1'b0;
        dec_min_d = 1'b0;
        clr_sec_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (man_sync_q) state_d = ST_SET_HR;
                else            state_d = ST_RUN;
            end
            ST_SET_HR: begin
                if (!man_sync_q) begin
                    state_d = ST_RUN;
                end else if (evt_q[0]) begin
                    state_d = ST_SET_MIN;
                end else begin
                    inc_hr_d = up_s;
                    dec_hr_d = dn_s;
                end
            end
            ST_SET_MIN: begin
                if (!man_sync_q) begin
                    state_d = ST_RUN;
                end else if (evt_q[0]) begin
                    state_d = ST_SET_SEC;
                end else begin
                    inc_min_d = up_s;
                    dec_min_d = dn_s;
                end
            end
            ST_SET_SEC: begin
                if (!man_sync_q) begin
                    state_d = ST_RUN;
                end else if (evt_q[0]) begin
                    state_d = ST_SET_HR;
                end else begin
                    clr_sec_d = up_s | dn_s;
                end
            end
            default: state_d = ST_RUN;
        endcase
        run_en_d = (state_d == ST_RUN);
    end

    assign adj_s = inc_hr_d | dec_hr_d | inc_min_d | dec_min_d | clr_sec_d;

    // Blink phase restarts (digits visible) on any state change or adjustment.
    always_comb begin
        if ((state_d != state_q) || adj_s || (state_d == ST_RUN)) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (tick_1khz) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_ONE;
                phase_d     = phase_q;
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
            phase_d     = phase_q;
        end
        case (state_d)
            ST_SET_HR:  blank_mask_d = {phase_d, phase_d, 4'b0000};
            ST_SET_MIN: blank_mask_d = {2'b00, phase_d, phase_d, 2'b00};
            ST_SET_SEC: blank_mask_d = {4'b0000, phase_d, phase_d};
            default:    blank_mask_d = 6'b000000;
        endcase
    end

    // Mode FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            run_en_q     <= 1'b1;
            inc_hr_q     <= 1'b0;
            dec_hr_q     <= 1'b0;
            inc_min_q    <= 1'b0;
            dec_min_q    <= 1'b0;
            clr_sec_q    <= 1'b0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            blank_mask_q <= 6'b000000;
        end else begin
            state_q      <= state_d;
            run_en_q     <= run_en_d;
            inc_hr_q     <= inc_hr_d;
            dec_hr_q     <= dec_hr_d;
            inc_min_q    <= inc_min_d;
            dec_min_q    <= dec_min_d;
            clr_sec_q    <= clr_sec_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            blank_mask_q <= blank_mask_d;
        end
    end

    assign run_en     = run_en_q;
    assign mode       = state_q;
    assign inc_hr     = inc_hr_q;
    assign dec_hr     = dec_hr_q;
    assign inc_min    = inc_min_q;
    assign dec_min    = dec_min_q;
    assign clr_sec    = clr_sec_q;
    assign blank_mask = blank_mask_q;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Directed and randomized bench for rtc_set_ctrl with a behavioural reference
// for mode sequencing, repeat pulse counts and blink phase.
module tb_rtc_set_ctrl;

    localparam int DEB   = 4;
    localparam int RDLY  = 20;
    localparam int RRATE = 5;
    localparam int BH    = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       man_sw = 1'b0;
    logic [2:0] push_but = 3'b111;
    logic       run_en, inc_hr, dec_hr, inc_min, dec_min, clr_sec;
    logic [1:0] mode;
    logic [5:0] blank_mask;

    int n_pass = 0, n_total = 0, n_fail = 0;
    int cyc = 0, n_ticks = 0;
    int c_inc_hr = 0, c_dec_hr = 0, c_inc_min = 0, c_dec_min = 0, c_clr_sec = 0;
    int wide_cnt = 0, run_pulse = 0, inc_min_tick = 0;
    logic prev_any = 1'b0;
    bit   blink_on = 1'b0, blink_sync = 1'b0;
    int   ts = 0, blink_err = 0, blink_hi = 0;
    logic [1:0] prev_mode = 2'd0;
    int   exp_mode, p_hold, stable_start;

    rtc_set_ctrl #(.DEB_LEN(DEB), .RPT_DLY(RDLY), .RPT_RATE(RRATE), .BLINK_HALF(BH)) dut (
        .clk(clk), .rst(rst), .tick_1khz(tick), .man_sw(man_sw), .push_but(push_but),
        .run_en(run_en), .mode(mode), .inc_hr(inc_hr), .dec_hr(dec_hr),
        .inc_min(inc_min), .dec_min(dec_min), .clr_sec(clr_sec), .blank_mask(blank_mask)
    );

    always #5 clk = ~clk;

    function automatic int next_mode(input int m);
        return (m % 3) + 1;
    endfunction

    function automatic int hold_pulses(input int p);
        return 1 + ((p >= RDLY) ? 1 + (p - RDLY) / RRATE : 0);
    endfunction

    function automatic int total_pulses();
        return c_inc_hr + c_dec_hr + c_inc_min + c_dec_min + c_clr_sec;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        c_inc_hr = 0; c_dec_hr = 0; c_inc_min = 0; c_dec_min = 0; c_clr_sec = 0;
    endtask

    task automatic clk_step();
        logic       any;
        logic [5:0] exp_mask;
        @(posedge clk);
        #1;
        if (tick) n_ticks++;
        if (inc_hr)  c_inc_hr++;
        if (dec_hr)  c_dec_hr++;
        if (inc_min) begin c_inc_min++; inc_min_tick = n_ticks; end
        if (dec_min) c_dec_min++;
        if (clr_sec) c_clr_sec++;
        any = inc_hr | dec_hr | inc_min | dec_min | clr_sec;
        if (any && prev_any) wide_cnt++;
        if (any && run_en) run_pulse++;
        prev_any = any;
        if (blink_on) begin
            if (inc_hr || (mode != prev_mode)) begin
                ts = 0;
                blink_sync = 1'b1;
            end else if (tick) begin
                ts++;
            end
            if (blink_sync && (mode == 2'd1)) begin
                exp_mask = (((ts / BH) % 2) == 1) ? 6'b110000 : 6'b000000;
                if (blank_mask !== exp_mask) blink_err++;
                if (blank_mask == 6'b110000) blink_hi++;
            end
        end
        prev_mode = mode;
        cyc++;
        tick = ((cyc % 4) == 0);
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = n_ticks + n;
        while (n_ticks < target) clk_step();
    endtask

    task automatic press(input int b, input int nt);
        push_but[b] = 1'b0;
        wait_ticks(nt);
        push_but[b] = 1'b1;
        wait_ticks(8);
    endtask

    initial begin
        // Reset release in RUN, idle
        repeat (3) clk_step();
        rst = 1'b0;
        repeat (200) clk_step();
        check("s1_run_en", run_en, 1);
        check("s1_mode", mode, 0);
        check("s1_mask", blank_mask, 0);
        check("s1_pulses", total_pulses(), 0);

        // Entry latency and next sequencing
        man_sw = 1'b1;
        clk_step(); clk_step();
        check("s2_mode_2clk", mode, 0);
        clk_step();
        check("s2_mode_3clk", mode, 1);
        check("s2_run_en_3clk", run_en, 0);
        exp_mode = 1;
        for (int i = 0; i < 4; i++) begin
            press(0, $urandom_range(5, 12));
            exp_mode = next_mode(exp_mode);
            check("s2_next_mode", mode, exp_mode);
        end

        // Bouncing up press in SET_MIN
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            push_but[1] = 1'($urandom_range(0, 1));
            wait_ticks(1);
        end
        push_but[1] = 1'b0;
        stable_start = n_ticks;
        wait_ticks(8);
        push_but[1] = 1'b1;
        wait_ticks(8);
        check("s3_inc_min", c_inc_min, 1);
        check("s3_other", total_pulses() - c_inc_min, 0);
        check("s3_latency", ((inc_min_tick - stable_start) <= DEB + 1) ? 1 : 0, 1);

        // Held down button in SET_HR
        press(0, 6); press(0, 6);
        check("s4_mode", mode, 1);
        clear_counts();
        push_but[2] = 1'b0; wait_ticks(52); push_but[2] = 1'b1; wait_ticks(8);
        check("s4_dec_hr_52", c_dec_hr, hold_pulses(52));
        clear_counts();
        wait_ticks(25);
        check("s4_stop", c_dec_hr, 0);
        p_hold = 5 * $urandom_range(0, 10) + 22 + $urandom_range(0, 1);
        push_but[2] = 1'b0; wait_ticks(p_hold); push_but[2] = 1'b1; wait_ticks(8);
        check("s4_dec_hr_rand", c_dec_hr, hold_pulses(p_hold));
        check("s4_inc_hr", c_inc_hr, 0);

        // Button held across leaving and re-entering set mode
        clear_counts();
        push_but[1] = 1'b0;
        wait_ticks(8);
        man_sw = 1'b0;
        wait_ticks(5);
        check("s4_run_mode", mode, 0);
        man_sw = 1'b1;
        wait_ticks(40);
        push_but[1] = 1'b1;
        wait_ticks(8);
        check("s4_reenter_inc", c_inc_hr, 1);
        check("s4_reenter_mode", mode, 1);

        // SET_SEC rules
        press(0, 6); press(0, 6);
        check("s5_mode", mode, 3);
        clear_counts();
        push_but[2:1] = 2'b00; wait_ticks(6); push_but[2:1] = 2'b11; wait_ticks(8);
        check("s5_both", total_pulses(), 0);
        press(1, 6);
        check("s5_clr_sec", c_clr_sec, 1);
        clear_counts();
        push_but[1:0] = 2'b00; wait_ticks(6); push_but[1:0] = 2'b11; wait_ticks(8);
        check("s5_next_up_mode", mode, 1);
        check("s5_next_up_pulse", total_pulses(), 0);

        // Blink in SET_HR, restarted by inc_hr
        clear_counts();
        blink_on = 1'b1; blink_sync = 1'b0; blink_err = 0; blink_hi = 0;
        press(1, 6);
        wait_ticks(25 + $urandom_range(0, 5));
        press(1, 6);
        wait_ticks(30);
        blink_on = 1'b0;
        check("s6_blink_err", blink_err, 0);
        check("s6_blink_seen", (blink_hi > 0) ? 1 : 0, 1);
        check("s6_inc_hr", c_inc_hr, 2);
        man_sw = 1'b0;
        repeat (3) clk_step();
        check("s6_exit_mode", mode, 0);
        check("s6_exit_run_en", run_en, 1);
        check("s6_exit_mask", blank_mask, 0);

        // Asynchronous reset mid-repeat, man_sw held through reset
        man_sw = 1'b1;
        wait_ticks(2);
        push_but[2] = 1'b0;
        wait_ticks(30);
        #2;
        rst = 1'b1;
        #1;
        check("s7_rst_run_en", run_en, 1);
        check("s7_rst_mode", mode, 0);
        check("s7_rst_mask", blank_mask, 0);
        check("s7_rst_dec_hr", dec_hr, 0);
        push_but[2] = 1'b1;
        repeat (3) clk_step();
        rst = 1'b0;
        clk_step(); clk_step();
        check("s7_mode_2clk", mode, 0);
        clk_step();
        check("s7_mode_3clk", mode, 1);
        check("s7_run_en_3clk", run_en, 0);

        check("pulse_width", wide_cnt, 0);
        check("pulse_in_run", run_pulse, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
